// File: rtl/m_fetch_queue.sv
// Instruction fetch queue: sequential PC generation, one-cycle-latency imem requests,
// and a small {pc, ir} FIFO drained by decode through a valid/ready handshake.
module m_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr,
    input  logic [31:0] w_imem_data,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic        w_id_valid,
    input  logic        w_id_ready,
    output logic [31:0] w_ir,
    output logic [31:0] w_pc
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [31:0]     NOP_IR   = 32'h0000_0013;

    logic [31:0]   pc_r;
    logic [31:0]   req_pc_r;
    logic          inflight_r;
    logic          kill_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [31:0]   fifo_pc_r [DEPTH];
    logic [31:0]   fifo_ir_r [DEPTH];

    logic [31:0]   redirect_tgt_s;
    logic          head_valid_s;
    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic [CW:0]   occ_s;
    logic [CW:0]   lim_s;
    logic [CW-1:0] count_nxt_s;

    // Handshake qualification and issue decision; issuing only when the response is sure to fit.
    always_comb begin
        redirect_tgt_s = {w_redirect_pc[31:2], 2'b00};
        head_valid_s   = (count_r != {CW{1'b0}});
        pop_s          = head_valid_s & w_id_ready & ~w_redirect;
        push_s         = inflight_r & ~kill_r & ~w_redirect;
        occ_s          = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
        lim_s          = DEPTH_W + {{CW{1'b0}}, pop_s};
        // Gated by the reset pin so the request is low while reset is held.
        issue_s        = w_rst_n & ~w_redirect & (occ_s < lim_s);
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Fetch control state; a redirect overrides every other update in its cycle.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= RESET_PC;
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
        end else if (w_redirect) begin
            pc_r       <= redirect_tgt_s;
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
        end else begin
            inflight_r <= issue_s;
            kill_r     <= 1'b0;
            count_r    <= count_nxt_s;
            if (issue_s) begin
                pc_r     <= pc_r + 32'd4;
                req_pc_r <= pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; each entry pairs the returned word with the address that fetched it.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i] <= 32'h0000_0000;
                fifo_ir_r[i] <= NOP_IR;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r] <= req_pc_r;
            fifo_ir_r[wr_ptr_r] <= w_imem_data;
        end
    end

    // Output drive; decode-facing signals depend on registered state only.
    always_comb begin
        w_imem_req  = issue_s;
        w_imem_addr = pc_r;
        w_id_valid  = head_valid_s;
        if (head_valid_s) begin
            w_ir = fifo_ir_r[rd_ptr_r];
            w_pc = fifo_pc_r[rd_ptr_r];
        end else begin
            w_ir = NOP_IR;
            w_pc = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue: start-up, backpressure, redirects, PC wrap and mid-stream reset.
module tb_m_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] ir;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    m_fetch_queue #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .w_clk        (clk),
        .w_rst_n      (rst_n),
        .w_imem_req   (imem_req),
        .w_imem_addr  (imem_addr),
        .w_imem_data  (imem_data),
        .w_redirect   (redirect),
        .w_redirect_pc(redirect_pc),
        .w_id_valid   (id_valid),
        .w_id_ready   (id_ready),
        .w_ir         (ir),
        .w_pc         (pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory with one-cycle latency.
    always @(posedge clk) begin
        if (imem_req === 1'b1) imem_data <= imem_addr ^ XOR_KEY;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) cyc();
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
        checks++; if (ir !== 32'h13) begin errors++; $display("FAIL reset_ir: got %h expected 00000013", ir); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    endtask

    task automatic test_start();
        cyc(); rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL start_req0: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL start_valid0: got %b expected 0", id_valid); end
        cyc(); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL start_req1: got req=%b addr=%h expected req=1 addr=00000104", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL start_valid1: got %b expected 0", id_valid); end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] e;
            e = 32'h100 + 32'(4 * k);
            cyc(); #1;
            checks++; if (id_valid !== 1'b1 || pc !== e || ir !== (e ^ XOR_KEY)) begin errors++; $display("FAIL start_head%0d: got v=%b pc=%h ir=%h expected v=1 pc=%h ir=%h", k, id_valid, pc, ir, e, e ^ XOR_KEY); end
        end
    endtask

    task automatic test_backpressure();
        cyc(); redirect = 1'b1; redirect_pc = 32'h400; id_ready = 1'b1; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_redirect_req: got %b expected 0", imem_req); end
        cyc(); redirect = 1'b0; id_ready = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || id_valid !== 1'b0) begin errors++; $display("FAIL bp_first_req: got req=%b addr=%h v=%b expected req=1 addr=00000400 v=0", imem_req, imem_addr, id_valid); end
        cyc(); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin errors++; $display("FAIL bp_second_req: got req=%b addr=%h expected req=1 addr=00000404", imem_req, imem_addr); end
        for (int s = 0; s < 4; s++) begin
            cyc(); #1;
            checks++; if (id_valid !== 1'b1 || pc !== 32'h400 || ir !== (32'h400 ^ XOR_KEY)) begin errors++; $display("FAIL bp_head_stable%0d: got v=%b pc=%h ir=%h expected v=1 pc=00000400", s, id_valid, pc, ir); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low%0d: got %b expected 0", s, imem_req); end
        end
        cyc(); id_ready = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h408) begin errors++; $display("FAIL bp_resume_req: got req=%b addr=%h expected req=1 addr=00000408", imem_req, imem_addr); end
        checks++; if (pc !== 32'h400) begin errors++; $display("FAIL bp_release_head: got %h expected 00000400", pc); end
        for (int k = 1; k < 4; k++) begin
            logic [31:0] e;
            e = 32'h400 + 32'(4 * k);
            cyc(); #1;
            checks++; if (id_valid !== 1'b1 || pc !== e) begin errors++; $display("FAIL bp_after%0d: got v=%b pc=%h expected v=1 pc=%h", k, id_valid, pc, e); end
        end
    endtask

    task automatic test_redirect_inflight();
        cyc(); redirect = 1'b1; redirect_pc = 32'h2003; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_in_redirect: got %b expected 0", imem_req); end
        cyc(); redirect = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL rd_target_addr: got req=%b addr=%h expected req=1 addr=00002000", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_t1: got %b expected 0", id_valid); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_t2: got %b expected 0", id_valid); end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] e;
            e = 32'h2000 + 32'(4 * k);
            cyc(); #1;
            checks++; if (id_valid !== 1'b1 || pc !== e || ir !== (e ^ XOR_KEY)) begin errors++; $display("FAIL rd_stream%0d: got v=%b pc=%h ir=%h expected v=1 pc=%h", k, id_valid, pc, ir, e); end
        end
    endtask

    task automatic test_redirect_full();
        cyc(); id_ready = 1'b0;
        cyc();
        cyc(); #1;
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b1 || pc !== 32'h200C) begin errors++; $display("FAIL rf_full: got req=%b v=%b pc=%h expected req=0 v=1 pc=0000200c", imem_req, id_valid, pc); end
        cyc(); id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h3000; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_req_in_redirect: got %b expected 0", imem_req); end
        cyc(); redirect = 1'b0; #1;
        checks++; if (id_valid !== 1'b0 || imem_addr !== 32'h3000 || imem_req !== 1'b1) begin errors++; $display("FAIL rf_flushed: got v=%b req=%b addr=%h expected v=0 req=1 addr=00003000", id_valid, imem_req, imem_addr); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rf_valid_t2: got %b expected 0", id_valid); end
        for (int k = 0; k < 2; k++) begin
            logic [31:0] e;
            e = 32'h3000 + 32'(4 * k);
            cyc(); #1;
            checks++; if (id_valid !== 1'b1 || pc !== e) begin errors++; $display("FAIL rf_stream%0d: got v=%b pc=%h expected v=1 pc=%h", k, id_valid, pc, e); end
        end
    endtask

    task automatic test_wrap();
        cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_req_in_redirect: got %b expected 0", imem_req); end
        cyc(); redirect = 1'b0; #1;
        checks++; if (imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffff8", imem_addr); end
        cyc(); #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1: got %h expected fffffffc", imem_addr); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            e = 32'hFFFF_FFF8 + 32'(4 * k);
            cyc(); #1;
            checks++; if (id_valid !== 1'b1 || pc !== e || ir !== (e ^ XOR_KEY)) begin errors++; $display("FAIL wrap_stream%0d: got v=%b pc=%h ir=%h expected v=1 pc=%h ir=%h", k, id_valid, pc, ir, e, e ^ XOR_KEY); end
        end
    endtask

    task automatic test_reset_midstream();
        cyc(); id_ready = 1'b0; #1;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid: got %b expected 1", id_valid); end
        rst_n = 1'b0; #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL mr_req: got req=%b addr=%h expected req=0 addr=00000100", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0 || ir !== 32'h13 || pc !== 32'h0) begin errors++; $display("FAIL mr_outputs: got v=%b ir=%h pc=%h expected v=0 ir=00000013 pc=00000000", id_valid, ir, pc); end
        cyc(); rst_n = 1'b1; id_ready = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mr_restart_req: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mr_no_stale: got v=%b pc=%h expected v=0", id_valid, pc); end
        for (int k = 0; k < 2; k++) begin
            logic [31:0] e;
            e = 32'h100 + 32'(4 * k);
            cyc(); #1;
            checks++; if (id_valid !== 1'b1 || pc !== e || ir !== (e ^ XOR_KEY)) begin errors++; $display("FAIL mr_stream%0d: got v=%b pc=%h ir=%h expected v=1 pc=%h", k, id_valid, pc, ir, e); end
        end
    endtask

    initial begin
        imem_data = 32'h0;
        test_reset();
        test_start();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
